// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// rtl/cv32e40p_rf_recovery_ctrl.sv - register-file rollback sequencer from checkpoint memory
//
// Purpose: on start_i, halts the core (recover_o), then reads register pairs
// from checkpoint memory one pair at a time. Each pair is written back through
// two RF write ports in a single cycle. x0 is never written.
//
// Ports:
//   clk_i, rst_ni              core clock, asynchronous active-low reset
//   start_i                    request a rollback (ignored while busy)
//   core_halted_i              core pipeline quiescent, RF may be written
//   busy_o, done_o             sequence active / one-cycle completion pulse
//   recover_o                  hands the RF write ports to this block
//   ckpt_req_o/gnt_i/addr_o    checkpoint read request, pair index p
//   ckpt_rvalid_i/rdata_i      checkpoint response {reg 2p+1, reg 2p}
//   regfile_*_a_o              write port A, even register 2p
//   regfile_*_b_o              write port B, odd register 2p+1
module cv32e40p_rf_recovery_ctrl #(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        core_halted_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        recover_o,
  output logic        ckpt_req_o,
  input  logic        ckpt_gnt_i,
  output logic [4:0]  ckpt_addr_o,
  input  logic        ckpt_rvalid_i,
  input  logic [63:0] ckpt_rdata_i,
  output logic        regfile_we_a_o,
  output logic [5:0]  regfile_waddr_a_o,
  output logic [31:0] regfile_wdata_a_o,
  output logic        regfile_we_b_o,
  output logic [5:0]  regfile_waddr_b_o,
  output logic [31:0] regfile_wdata_b_o
);

  localparam int unsigned NUM_PAIRS = NUM_REGS / 2;
  localparam logic [4:0]  LAST_PAIR = 5'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  pair_q, pair_d;
  logic        recover_q, recover_d;
  logic        we_a_q, we_a_d;
  logic        we_b_q, we_b_d;
  logic [5:0]  waddr_a_q, waddr_a_d;
  logic [5:0]  waddr_b_q, waddr_b_d;
  logic [31:0] wdata_a_q, wdata_a_d;
  logic [31:0] wdata_b_q, wdata_b_d;

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    we_a_d    = 1'b0;
    we_b_d    = 1'b0;
    waddr_a_d = waddr_a_q;
    waddr_b_d = waddr_b_q;
    wdata_a_d = wdata_a_q;
    wdata_b_d = wdata_b_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_HALT;
          pair_d  = 5'd0;
        end
      end
      S_HALT: begin
        if (core_halted_i) state_d = S_REQ;
      end
      S_REQ: begin
        if (ckpt_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        // The write-port registers are loaded on the way into WRITE, so the
        // response data itself is captured here and the pulse lines up with
        // the WRITE state.
        if (ckpt_rvalid_i) begin
          state_d   = S_WRITE;
          we_a_d    = (pair_q != 5'd0);
          we_b_d    = 1'b1;
          waddr_a_d = {pair_q, 1'b0};
          waddr_b_d = {pair_q, 1'b1};
          wdata_a_d = ckpt_rdata_i[31:0];
          wdata_b_d = ckpt_rdata_i[63:32];
        end
      end
      S_WRITE: begin
        if (pair_q == LAST_PAIR) begin
          state_d = S_DONE;
        end else begin
          pair_d  = pair_q + 5'd1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    recover_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pair_q    <= 5'd0;
      recover_q <= 1'b0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= 6'd0;
      waddr_b_q <= 6'd0;
      wdata_a_q <= 32'd0;
      wdata_b_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      recover_q <= recover_d;
      we_a_q    <= we_a_d;
      we_b_q    <= we_b_d;
      waddr_a_q <= waddr_a_d;
      waddr_b_q <= waddr_b_d;
      wdata_a_q <= wdata_a_d;
      wdata_b_q <= wdata_b_d;
    end
  end

  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign recover_o         = recover_q;
  assign ckpt_req_o        = (state_q == S_REQ);
  assign ckpt_addr_o       = pair_q;
  assign regfile_we_a_o    = we_a_q;
  assign regfile_waddr_a_o = waddr_a_q;
  assign regfile_wdata_a_o = wdata_a_q;
  assign regfile_we_b_o    = we_b_q;
  assign regfile_waddr_b_o = waddr_b_q;
  assign regfile_wdata_b_o = wdata_b_q;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// tb/tb_cv32e40p_rf_recovery_ctrl.sv - self-checking bench for the RF rollback sequencer
module tb_cv32e40p_rf_recovery_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        halted;
  logic        start [2];
  logic        gnt   [2];
  logic        rv    [2];
  logic [63:0] rd    [2];
  logic        busy  [2];
  logic        done  [2];
  logic        rec   [2];
  logic        req   [2];
  logic [4:0]  addr  [2];
  logic        we_a  [2];
  logic        we_b  [2];
  logic [5:0]  wa_a  [2];
  logic [5:0]  wa_b  [2];
  logic [31:0] wd_a  [2];
  logic [31:0] wd_b  [2];

  cv32e40p_rf_recovery_ctrl #(.NUM_REGS(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .core_halted_i(halted),
    .busy_o(busy[0]), .done_o(done[0]), .recover_o(rec[0]),
    .ckpt_req_o(req[0]), .ckpt_gnt_i(gnt[0]), .ckpt_addr_o(addr[0]),
    .ckpt_rvalid_i(rv[0]), .ckpt_rdata_i(rd[0]),
    .regfile_we_a_o(we_a[0]), .regfile_waddr_a_o(wa_a[0]), .regfile_wdata_a_o(wd_a[0]),
    .regfile_we_b_o(we_b[0]), .regfile_waddr_b_o(wa_b[0]), .regfile_wdata_b_o(wd_b[0])
  );

  cv32e40p_rf_recovery_ctrl #(.NUM_REGS(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .core_halted_i(halted),
    .busy_o(busy[1]), .done_o(done[1]), .recover_o(rec[1]),
    .ckpt_req_o(req[1]), .ckpt_gnt_i(gnt[1]), .ckpt_addr_o(addr[1]),
    .ckpt_rvalid_i(rv[1]), .ckpt_rdata_i(rd[1]),
    .regfile_we_a_o(we_a[1]), .regfile_waddr_a_o(wa_a[1]), .regfile_wdata_a_o(wd_a[1]),
    .regfile_we_b_o(we_b[1]), .regfile_waddr_b_o(wa_b[1]), .regfile_wdata_b_o(wd_b[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Checkpoint contents: a distinct word per architectural register index.
  function automatic logic [31:0] word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
  endfunction

  function automatic logic [63:0] pair_data(input int p);
    return {word(2 * p + 1), word(2 * p)};
  endfunction

  // Reference model state: next pair expected, write log, shadow RF.
  int          exp_p     [2];
  int          nwr       [2];
  int          ndone     [2];
  int          done_cyc  [2];
  int          last_wa   [2];
  int          last_wb   [2];
  int          wcnt      [2][64];
  logic [31:0] shadow    [2][64];
  bit          prev_done [2];
  bit          quiet = 1'b0;

  // Checkpoint memory model knobs and state.
  int slow_pair = -1;
  int gnt_dly_s = 0;
  int rv_dly_s  = 0;
  bit spur      = 1'b0;
  int req_cnt [2];
  int rv_cnt  [2];
  int pend_p  [2];
  bit pend    [2];

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      exp_p[k] = 0; nwr[k] = 0; ndone[k] = 0; done_cyc[k] = 0;
      last_wa[k] = 0; last_wb[k] = 0; prev_done[k] = 1'b0; req_cnt[k] = 0;
      for (int i = 0; i < 64; i++) begin
        wcnt[k][i] = 0;
        shadow[k][i] = 32'd0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      gnt[k] = 1'b0;
      rv[k]  = 1'b0;
      rd[k]  = 64'hDEAD_BEEF_0BAD_F00D;
      if (pend[k]) begin
        if (rv_cnt[k] == 0) begin
          rv[k]   = 1'b1;
          rd[k]   = pair_data(pend_p[k]);
          pend[k] = 1'b0;
        end else begin
          rv_cnt[k]--;
        end
      end else if (req[k]) begin
        if (spur) rv[k] = 1'b1;
        if (req_cnt[k] >= ((int'(addr[k]) == slow_pair) ? gnt_dly_s : 0)) begin
          gnt[k]     = 1'b1;
          pend[k]    = 1'b1;
          pend_p[k]  = int'(addr[k]);
          rv_cnt[k]  = (int'(addr[k]) == slow_pair) ? rv_dly_s : 0;
          req_cnt[k] = 0;
        end else begin
          req_cnt[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        n = (k == 1) ? 64 : 32;
        if (quiet) begin
          chk("quiet_ctrl", {busy[k], done[k], rec[k], req[k], we_a[k], we_b[k]}, 64'd0);
          chk("quiet_addr", {addr[k], wa_a[k], wa_b[k]}, 64'd0);
          chk("quiet_data", {wd_a[k], wd_b[k]}, 64'd0);
        end
        chk("busy_eq_recover", rec[k], busy[k]);
        if (prev_done[k]) chk("recover_low_after_done", rec[k], 1'b0);
        prev_done[k] = done[k];
        if (req[k]) begin
          chk("req_addr", addr[k], 64'(exp_p[k]));
          chk("req_while_recover", rec[k], 1'b1);
        end
        if (we_b[k]) begin
          chk("we_a", we_a[k], (exp_p[k] != 0));
          chk("waddr_a", wa_a[k], 64'(2 * exp_p[k]));
          chk("waddr_b", wa_b[k], 64'(2 * exp_p[k] + 1));
          chk("wdata_a", wd_a[k], word(2 * exp_p[k]));
          chk("wdata_b", wd_b[k], word(2 * exp_p[k] + 1));
          if (we_a[k]) begin
            wcnt[k][wa_a[k]]++;
            shadow[k][wa_a[k]] = wd_a[k];
          end
          wcnt[k][wa_b[k]]++;
          shadow[k][wa_b[k]] = wd_b[k];
          last_wa[k] = int'(wa_a[k]);
          last_wb[k] = int'(wa_b[k]);
          exp_p[k]++;
          nwr[k]++;
        end else if (we_a[k]) begin
          chk("we_a_without_we_b", we_b[k], 1'b1);
        end
        if (done[k]) begin
          chk("done_after_all_pairs", 64'(exp_p[k]), 64'(n / 2));
          ndone[k]++;
          done_cyc[k] = cyc;
        end
      end
    end
  end

  int t0;

  task automatic do_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    while (ndone[k] == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_budget", (ndone[k] != 0), 1'b1);
    repeat (4) @(negedge clk);
    chk("done_once", 64'(ndone[k]), 64'd1);
    chk("idle_after_done", {busy[k], rec[k], req[k]}, 64'd0);
  endtask

  task automatic check_shadow(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        chk("x0_never_written", 64'(wcnt[k][0]), 64'd0);
      end else begin
        chk($sformatf("wr_count[%0d]", i), 64'(wcnt[k][i]), 64'd1);
        chk($sformatf("wr_data[%0d]", i), shadow[k][i], word(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    halted = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctrl", {busy[k], done[k], rec[k], req[k], we_a[k], we_b[k]}, 64'd0);
      chk("reset_addr", {addr[k], wa_a[k], wa_b[k]}, 64'd0);
      chk("reset_data", {wd_a[k], wd_b[k]}, 64'd0);
    end
    #2 rst_n = 1'b1;

    // Zero-wait rollback; halted drops after HALT and must not stall it.
    do_start(0);
    @(negedge clk);
    @(negedge clk);
    halted = 1'b0;
    wait_done(0, 200);
    halted = 1'b1;
    chk("t1_done_cycle", 64'(done_cyc[0] - t0), 64'd50);
    chk("t1_writes", 64'(nwr[0]), 64'd16);
    check_shadow(0, 32);

    // Core slow to halt.
    #2 clear_model();
    halted = 1'b0;
    do_start(0);
    for (int i = 0; i < 10; i++) begin
      chk("t2_halt_recover", rec[0], 1'b1);
      chk("t2_halt_busy", busy[0], 1'b1);
      chk("t2_halt_no_req", req[0], 1'b0);
      @(negedge clk);
    end
    halted = 1'b1;
    @(negedge clk);
    chk("t2_req_after_halted", req[0], 1'b1);
    wait_done(0, 200);
    chk("t2_writes", 64'(nwr[0]), 64'd16);
    check_shadow(0, 32);

    // Slow memory on pair 5, spurious rvalid in REQ, start pulses while busy.
    #2 clear_model();
    slow_pair = 5; gnt_dly_s = 3; rv_dly_s = 4; spur = 1'b1;
    do_start(0);
    repeat (10) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 300);
    spur = 1'b0; slow_pair = -1;
    chk("t3_done_cycle", 64'(done_cyc[0] - t0), 64'd57);
    chk("t3_writes", 64'(nwr[0]), 64'd16);
    check_shadow(0, 32);

    // Integer + FP register file.
    #2 clear_model();
    do_start(1);
    wait_done(1, 400);
    chk("t4_done_cycle", 64'(done_cyc[1] - t0), 64'd98);
    chk("t4_writes", 64'(nwr[1]), 64'd32);
    chk("t4_last_waddr_a", 64'(last_wa[1]), 64'd62);
    chk("t4_last_waddr_b", 64'(last_wb[1]), 64'd63);
    check_shadow(1, 64);

    // Reset while waiting on pair 7; its response lands after release.
    #2 clear_model();
    slow_pair = 7; gnt_dly_s = 0; rv_dly_s = 6;
    do_start(0);
    n = 0;
    while (!(req[0] && addr[0] == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_pair7", (req[0] && addr[0] == 5'd7), 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    quiet = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_write_after_reset", 64'(nwr[0]), 64'd7);
    chk("t5_no_done_after_reset", 64'(ndone[0]), 64'd0);
    quiet = 1'b0;
    slow_pair = -1;
    #2 clear_model();
    do_start(0);
    wait_done(0, 200);
    chk("t5_restart_writes", 64'(nwr[0]), 64'd16);
    check_shadow(0, 32);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rf_recovery_ctrl.md
CV32E40P_RF_RECOVERY_CTRL -- requirements
Module: cv32e40p_rf_recovery_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 32, SHALL set registers restored: 32 (integer RF) or 64 (integer + FP RF); must be even.
REQ-002 clk_i  in  1  core clock; one clock domain.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  request a register-file rollback from checkpoint.
REQ-005 core_halted_i  in  1  core pipeline quiescent, safe to write RF.
REQ-006 busy_o  out  1  high in every state except IDLE.
REQ-007 done_o  out  1  one-cycle pulse at end of rollback.
REQ-008 recover_o  out  1  drives core recover_i; forces RF write ports to this block.
REQ-009 ckpt_req_o  out  1  checkpoint memory request.
REQ-010 ckpt_gnt_i  in  1  checkpoint memory grant.
REQ-011 ckpt_addr_o  out  5  register-pair index p.
REQ-012 ckpt_rvalid_i  in  1  response valid.
REQ-013 ckpt_rdata_i  in  64  [31:0] = register 2p, [63:32] = register 2p+1.
REQ-014 regfile_we_a_o / regfile_waddr_a_o / regfile_wdata_a_o  out  1/6/32  RF write port A (even register).
REQ-015 regfile_we_b_o / regfile_waddr_b_o / regfile_wdata_b_o  out  1/6/32  RF write port B (odd register).

Function
REQ-016 FSM states SHALL be IDLE, HALT, REQ, WAIT, WRITE, DONE.
REQ-017 IDLE: start_i=1 -> HALT next cycle, pair counter p cleared to 0; start_i in any other state SHALL be ignored.
REQ-018 recover_o SHALL be high (registered) in HALT, REQ, WAIT, WRITE, DONE; low in IDLE.
REQ-019 HALT: remain until core_halted_i=1, then -> REQ.
REQ-020 REQ: ckpt_req_o=1, ckpt_addr_o=p held stable; ckpt_gnt_i=1 -> WAIT; req SHALL stay high until granted.
REQ-021 Only one outstanding checkpoint transaction; ckpt_req_o SHALL be 0 outside REQ.
REQ-022 WAIT: ckpt_rvalid_i=1 -> capture ckpt_rdata_i, -> WRITE; rvalid in any other state SHALL be ignored.
REQ-023 WRITE (exactly one cycle): waddr_a=2p, wdata_a=rdata[31:0]; waddr_b=2p+1, wdata_b=rdata[63:32]; we_b=1; we_a=1 except we_a=0 when 2p=0 (x0 never written).
REQ-024 WRITE exit: p=NUM_REGS/2-1 -> DONE; else p increments by 1, -> REQ.
REQ-025 Waddr bit 5 SHALL equal 1 for indices 32..63 (FP registers), i.e. waddr = 2p (+1) in 6 bits, no wrap.
REQ-026 DONE: done_o=1 for one cycle, recover_o falls the following cycle, -> IDLE.
REQ-027 All write-port outputs SHALL be registered; we_a/we_b SHALL be 0 outside WRITE; waddr/wdata hold last value.
REQ-028 Latency with core_halted_i already high, grant same-cycle, rvalid next cycle: 3 cycles per pair; start at cycle 0 -> done_o at cycle 2+3*NUM_REGS/2 (cycle 50 for NUM_REGS=32).
REQ-029 core_halted_i deasserting after HALT SHALL NOT stall the sequence.

Reset
REQ-030 rst_ni=0 SHALL asynchronously force IDLE, p=0, and all outputs 0 (busy, done, recover, ckpt_req, ckpt_addr, both we/waddr/wdata).
REQ-031 Reset mid-rollback SHALL abandon the sequence; no write pulse and no done_o after reset release until a new start_i.

Verification
REQ-032 NUM_REGS=32, halted=1, zero-wait memory returning {2p+1,2p} patterns: start at cycle 0 -> 16 WRITE pulses, x0 skipped, x1..x31 written with matching data, done_o at cycle 50.
REQ-033 core_halted_i held 0 for 10 cycles after start -> recover_o=1, busy_o=1, ckpt_req_o=0 throughout, REQ entered the cycle after halted rises.
REQ-034 ckpt_gnt_i delayed 3 cycles and rvalid delayed 4 cycles for pair 5 -> ckpt_req_o and ckpt_addr_o=5 stable until grant; writes of regs 10/11 occur once with correct data.
REQ-035 NUM_REGS=64 -> 32 pairs, last write waddr_a=62 and waddr_b=63, done_o once.
REQ-036 rst_ni pulled low during pair 7 WAIT, rvalid then arrives after release -> no write, no done_o, all outputs 0; new start restarts at p=0.
REQ-037 start_i pulsed while busy and spurious rvalid in REQ -> no effect on sequence or write count.
